shift_sub_divider: RTL and testbench

Sequential unsigned restoring divider for the MIPS CPU datapath. It is the counterpart of the shift-add multiplier: it resolves one quotient bit per clock by shift-and-subtract, instead of shift-and-add. It serves DIVU (and, with external sign handling, DIV), and writes the quotient and remainder that feed the LO and HI registers. An internal controller drives a remainder/quotient register with Load, Sh and Sub controls, analogous to the multiplier's ACC with Load, Sh and Ad.

---
 rtl/shift_sub_divider_pkg.sv | 12 +
 rtl/shift_sub_divider_if.sv | 30 +++
 rtl/shift_sub_divider_div_rq_reg.sv | 58 +++++
 rtl/shift_sub_divider.sv | 112 +++++++++++
 tb/tb_shift_sub_divider.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_sub_divider_pkg.sv
// Shared divider definitions: operand width, counter width and controller state encoding.
package shift_sub_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_e;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Start/operand/result bundle of the divider; state is exported so checkers can observe the FSM.
// Handshake: St is taken only while the divider is in IDLE (Busy=0); Done pulses for one cycle
// when Quociente/Resto/DivZero become valid, and those stay valid until the next accepted St.
interface shift_sub_divider_if
    import shift_sub_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             St;
    logic [WIDTH-1:0] Dividendo;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quociente;
    logic [WIDTH-1:0] Resto;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    div_state_e       state;

    modport master (
        output St, Dividendo, Divisor,
        input  Quociente, Resto, Busy, Done, DivZero, state
    );

    modport slave (
        input  St, Dividendo, Divisor,
        output Quociente, Resto, Busy, Done, DivZero, state
    );

endinterface

// File: rtl/shift_sub_divider_div_rq_reg.sv
// Partial remainder R, dividend/quotient Q and divisor D, with Load / Sh / Sub controls.
module div_rq_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             sh,
    input  logic             sub,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             trial_neg,
    output logic [WIDTH-1:0] quo_nxt,
    output logic [WIDTH-1:0] rem_nxt
);

    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH+1:0] shifted_r;
    logic [WIDTH+1:0] trial;

    // R never reaches D, so R[WIDTH] is always 0 and the one-bit-wider trial sign
    // equals the WIDTH+1-bit borrow while still consuming every bit of R.
    always_comb begin
        shifted_r = {r_q, q_q[WIDTH-1]};
        trial     = shifted_r - {2'b00, d_q};
        trial_neg = trial[WIDTH+1];

        r_d = r_q;
        q_d = q_q;
        d_d = d_q;
        if (load) begin
            r_d = '0;
            q_d = dividend;
            d_d = divisor;
        end else if (sh) begin
            r_d = sub ? trial[WIDTH:0] : shifted_r[WIDTH:0];
            q_d = {q_q[WIDTH-2:0], sub};
        end

        quo_nxt = q_d;
        rem_nxt = r_d[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else begin
            r_q <= r_d;
            q_q <= q_d;
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, registered results and Done pulse.
module shift_sub_divider
    import shift_sub_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    shift_sub_divider_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;

    logic             load, sh, sub;
    logic             trial_neg;
    logic [WIDTH-1:0] quo_nxt, rem_nxt;

    div_rq_reg #(.WIDTH(WIDTH)) u_rq (
        .clk      (Clk),
        .rst      (Reset),
        .load     (load),
        .sh       (sh),
        .sub      (sub),
        .dividend (bus.Dividendo),
        .divisor  (bus.Divisor),
        .trial_neg(trial_neg),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;
        load      = 1'b0;
        sh        = 1'b0;
        sub       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.St) begin
                    if (bus.Divisor == '0) begin
                        quo_d     = '1;
                        rem_d     = bus.Dividendo;
                        divzero_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        load      = 1'b1;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        divzero_d = 1'b0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                sh    = 1'b1;
                sub   = ~trial_neg;
                cnt_d = cnt_q + 1'b1;
                // Results are taken from this cycle's iteration, not the registered copy.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quo_d   = quo_nxt;
                    rem_d   = rem_nxt;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.Quociente = quo_q;
    assign bus.Resto     = rem_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DivZero   = divzero_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and randomized checks of shift_sub_divider against a / and % reference model.
module tb_shift_sub_divider;
    import shift_sub_divider_pkg::*;

    localparam int W = DIV_WIDTH;

    logic Clk;
    logic Reset;

    shift_sub_divider_if bus ();

    shift_sub_divider dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_quo_q[$];
    logic [W-1:0] exp_rem_q[$];
    logic         exp_dz_q[$];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one St cycle and push the reference result.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.St        = 1'b1;
        bus.Dividendo = a;
        bus.Divisor   = b;
        if (b == '0) begin
            exp_quo_q.push_back('1);
            exp_rem_q.push_back(a);
            exp_dz_q.push_back(1'b1);
        end else begin
            exp_quo_q.push_back(a / b);
            exp_rem_q.push_back(a % b);
            exp_dz_q.push_back(1'b0);
        end
        tick();
        bus.St        = 1'b0;
        bus.Dividendo = $urandom;
        bus.Divisor   = $urandom;
    endtask

    // Wait (bounded) for Done, then pop and compare; optionally check latency and Busy length.
    task automatic wait_done(input string tag, input bit chk_timing, input int already);
        int           lat;
        int           busy_n;
        int           exp_lat;
        logic [W-1:0] eq, er;
        logic         edz;
        lat    = already;
        busy_n = 0;
        while (bus.Done !== 1'b1 && lat < 100) begin
            if (bus.Busy === 1'b1) busy_n++;
            tick();
            lat++;
        end
        chk({tag, "_done_seen"}, bus.Done, 1'b1);
        chk({tag, "_exp_pending"}, exp_quo_q.size(), 1);
        if (bus.Done === 1'b1 && exp_quo_q.size() != 0) begin
            eq  = exp_quo_q.pop_front();
            er  = exp_rem_q.pop_front();
            edz = exp_dz_q.pop_front();
            chk({tag, "_quo"}, bus.Quociente, eq);
            chk({tag, "_rem"}, bus.Resto, er);
            chk({tag, "_divzero"}, bus.DivZero, edz);
            chk({tag, "_busy_at_done"}, bus.Busy, 1'b0);
            if (chk_timing) begin
                exp_lat = edz ? 0 : W;
                chk({tag, "_latency"}, lat, exp_lat);
                chk({tag, "_busy_cycles"}, busy_n, exp_lat);
            end
        end
    endtask

    initial begin
        logic [W-1:0] a, b;
        int           done_seen;

        Reset         = 1'b1;
        bus.St        = 1'b0;
        bus.Dividendo = '0;
        bus.Divisor   = '0;
        tick();
        tick();
        chk("rst_quo", bus.Quociente, 0);
        chk("rst_rem", bus.Resto, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_divzero", bus.DivZero, 0);
        chk("rst_state", bus.state, IDLE);
        Reset = 1'b0;
        tick();

        // 100 / 7 with full timing, then Done must drop after one cycle.
        start_op(32'd100, 32'd7);
        chk("t1_busy_edge0", bus.Busy, 1'b1);
        chk("t1_state_run", bus.state, RUN);
        wait_done("t1", 1'b1, 0);
        tick();
        chk("t1_done_one_cycle", bus.Done, 1'b0);
        chk("t1_quo_held", bus.Quociente, 32'd14);

        start_op(32'd7, 32'd496);
        wait_done("t2_small", 1'b1, 0);
        start_op(32'hFFFF_FFFF, 32'd1);
        wait_done("t2_div1", 1'b1, 0);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("t2_max", 1'b1, 0);
        tick();

        // Divide by zero completes in one cycle without Busy.
        start_op(32'd5, 32'd0);
        chk("t3_dz_busy", bus.Busy, 1'b0);
        wait_done("t3_dz", 1'b1, 0);
        tick();
        chk("t3_dz_done_clear", bus.Done, 1'b0);
        chk("t3_dz_held", bus.DivZero, 1'b1);
        start_op(32'd15, 32'd4);
        chk("t3_dz_cleared", bus.DivZero, 1'b0);
        wait_done("t3_15_4", 1'b1, 0);
        tick();

        // St during RUN is ignored.
        start_op(32'd1000, 32'd3);
        repeat (5) tick();
        bus.St        = 1'b1;
        bus.Dividendo = 32'd77;
        bus.Divisor   = 32'd5;
        tick();
        bus.St = 1'b0;
        wait_done("t4_ignore", 1'b0, 6);
        // St in the Done cycle is accepted immediately.
        start_op(32'd12345, 32'd100);
        chk("t4_b2b_busy", bus.Busy, 1'b1);
        chk("t4_b2b_done_clear", bus.Done, 1'b0);
        chk("t4_b2b_prev_quo_held", bus.Quociente, 32'd333);
        wait_done("t4_b2b", 1'b1, 0);
        tick();

        // Reset at iteration 10 aborts with no Done.
        start_op(32'd1000, 32'd7);
        repeat (10) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_quo_q.delete();
        exp_rem_q.delete();
        exp_dz_q.delete();
        chk("t5_rst_quo", bus.Quociente, 0);
        chk("t5_rst_rem", bus.Resto, 0);
        chk("t5_rst_busy", bus.Busy, 0);
        chk("t5_rst_done", bus.Done, 0);
        chk("t5_rst_divzero", bus.DivZero, 0);
        done_seen = 0;
        repeat (40) begin
            tick();
            if (bus.Done === 1'b1) done_seen++;
        end
        chk("t5_no_done_after_abort", done_seen, 0);
        start_op(32'd496, 32'd15);
        wait_done("t5_496_15", 1'b1, 0);
        tick();

        // Randomized pairs.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = '0;
                1: begin
                    a = $urandom_range(0, 100000);
                    b = a + 32'($urandom_range(1, 5000));
                end
                2: b = $urandom_range(1, 16);
                3: b = $urandom_range(0, 3);
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            start_op(a, b);
            wait_done("rnd", 1'b1, 0);
            if ($urandom_range(0, 1) == 0) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
